// File: rtl/dec_digits_to_bin_if.sv
`default_nettype none
// ============================================================================
// Module      : dec_digits_to_bin_if
// Description : Handshake bundle for the decimal-digit to binary decoder.
//               The digit word arrives with in_valid/in_ready, and the binary
//               result leaves with out_valid/out_ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface dec_digits_to_bin_if #(
  parameter int NDIG = 8,
  parameter int DW   = 32,
  parameter int OW   = 32
);
  // Input side: one word of NDIG digits. d[0] is the most significant digit.
  logic                     in_valid;
  logic                     in_ready;
  logic [NDIG-1:0][DW-1:0]  d;

  // Output side: binary result plus status flags
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OW-1:0]     result;
  logic                     digit_err;
  logic                     ovf;

  // Upstream producer and downstream consumer (the testbench)
  modport master (
    output in_valid, d, out_ready,
    input  in_ready, out_valid, result, digit_err, ovf
  );

  // The decoder itself
  modport slave (
    input  in_valid, d, out_ready,
    output in_ready, out_valid, result, digit_err, ovf
  );
endinterface
`default_nettype wire

// File: rtl/dec_digits_to_bin.sv
`default_nettype none
// ============================================================================
// Module      : dec_digits_to_bin
// Description : Horner-style decoder that turns NDIG base-10 digits (MSD
//               first) into a signed binary integer, one digit per clock.
//               x10 is formed as (acc<<3)+(acc<<1). The digit word is captured
//               on acceptance, so later changes on the inputs are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module dec_digits_to_bin #(
  parameter int NDIG = 8,
  parameter int DW   = 32,
  parameter int OW   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dec_digits_to_bin_if.slave   bus
);

  // Four guard bits let a word run past the OW range without wrapping,
  // which is what makes overflow detectable.
  localparam int AW = OW + 4;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [NDIG-1:0][DW-1:0] dig_q, dig_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    err_q, err_d;
  logic                    ovf_q, ovf_d;
  logic signed [OW-1:0]    result_q, result_d;

  logic                    accept;
  logic                    last_digit;
  logic [DW-1:0]           dig_sel;
  logic signed [AW-1:0]    dig_ext;
  logic signed [AW-1:0]    acc_x10;
  logic signed [AW-1:0]    acc_next;
  logic                    dig_bad;
  logic                    acc_oor;

  assign accept     = bus.in_valid && (state_q == S_IDLE);
  assign last_digit = (idx_q == IW'(NDIG - 1));
  assign dig_sel    = dig_q[idx_q];

  // Bring the selected digit to accumulator width while keeping its sign.
  generate
    if (DW >= AW) begin : g_dig_trunc
      assign dig_ext = $signed(dig_sel[AW-1:0]);
    end else begin : g_dig_sext
      assign dig_ext = $signed({{(AW-DW){dig_sel[DW-1]}}, dig_sel});
    end
  endgenerate

  // A digit is valid only when it lies in 0..9. The sign bit flags negatives.
  assign dig_bad  = dig_sel[DW-1] || (dig_sel > DW'(9));
  assign acc_x10  = (acc_q <<< 3) + (acc_q <<< 1);
  assign acc_next = acc_x10 + dig_ext;
  // The value fits in OW signed bits only when all guard bits match the OW sign bit.
  assign acc_oor  = !((&acc_next[AW-1:OW-1]) || !(|acc_next[AW-1:OW-1]));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: accept -> NDIG digit steps -> wait for consumer
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)        state_d = S_ACCUM;
      S_ACCUM: if (last_digit)    state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state. No input is accepted outside IDLE.
  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.out_valid = (state_q == S_DONE);
  end

  // Datapath next state: capture on accept, then one Horner step per ACCUM cycle
  always_comb begin
    dig_d    = dig_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    if (accept) begin
      dig_d = bus.d;
      acc_d = '0;
      idx_d = '0;
      err_d = 1'b0;
      ovf_d = 1'b0;
    end else if (state_q == S_ACCUM) begin
      acc_d = acc_next;
      idx_d = idx_q + 1'b1;
      err_d = err_q | dig_bad;
      ovf_d = ovf_q | acc_oor;
      // The result changes only when a word completes, so it holds through DONE and IDLE.
      if (last_digit) result_d = acc_next[OW-1:0];
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q    <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      dig_q    <= dig_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.digit_err = err_q;
  assign bus.ovf       = ovf_q;

endmodule
`default_nettype wire

// File: doc/dec_digits_to_bin.md
Name: dec_digits_to_bin

Overview:
- Sequential decoder that converts one word of normalized base-10 digits (0..9, most-significant first) back into a binary integer.
- It is the reading end of the digit-normalization stage that follows the FFT multiplier: the carry-propagation stage emits digit vectors, and this block turns them into a scalar result for compare/readback.
- Uses Horner evaluation, one digit per clock. Multiply-by-10 is built as (acc<<3)+(acc<<1); no hardware multiplier.
- Valid/ready handshakes on both sides.

Parameters:
- NDIG, 8, digits per word. d0 is the most significant digit, d(NDIG-1) the least.
- DW, 32, width of each signed digit input.
- OW, 32, width of the signed binary result.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  digit word present on d0..d7.
- in_ready  out  1  block can accept a word.
- d0..d7  in  DW each, signed  digits; d0 is the MSD.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- result  out  OW, signed  binary value of the digit word.
- digit_err  out  1  at least one digit of this word was outside 0..9.
- ovf  out  1  accumulator exceeded the signed OW range at some step.

Behaviour:
- Reset (async, rst_n=0), all of these take effect immediately:
  - state=IDLE, in_ready=1, out_valid=0, result=0, digit_err=0, ovf=0.
  - Digit registers, accumulator and index cleared.
- States and transitions:
  - IDLE:
    - in_ready=1.
    - On in_valid & in_ready: latch all NDIG digits, acc=0, idx=0, clear err/ovf. Go to ACCUM.
  - ACCUM:
    - in_ready=0.
    - Each cycle: acc <= acc*10 + digit[idx], then idx++.
    - When idx==NDIG-1 on this edge, go to DONE.
  - DONE:
    - out_valid=1; result, digit_err and ovf hold steady.
    - On out_ready: go to IDLE, out_valid=0 on the next edge.
    - result keeps its last value until the next word completes.
- Latency:
  - Accept edge E0. Digits are consumed on edges E1..E(NDIG).
  - out_valid is high after edge E(NDIG), i.e. 8 cycles after acceptance with NDIG=8.
- Throughput: one word per NDIG+2 cycles minimum. in_ready is low in ACCUM and DONE, so no overlap.
- Arithmetic:
  - acc is OW+4 bits wide internally, signed.
  - result is the low OW bits of acc.
- digit_err:
  - Set if any latched digit is <0 or >9.
  - Evaluated during ACCUM; sticky until the next accept.
  - Computation still completes using the raw signed digit values.
- ovf:
  - Set if, after any ACCUM step, acc lies outside [-2^(OW-1), 2^(OW-1)-1].
  - Sticky for the word.
  - Cannot occur with all-valid digits at NDIG=8, OW=32.
- Backpressure:
  - out_ready low in DONE: hold indefinitely with outputs stable.
  - in_valid during ACCUM or DONE is ignored. The upstream must hold its word until in_ready.
- Simultaneous events:
  - in_valid while in DONE with out_ready=1: not accepted that cycle. in_ready rises only in IDLE.
- Reset mid-ACCUM or mid-DONE: the word is abandoned, no out_valid pulse, and the block returns to IDLE.
- Digits are sampled only at the accept edge. Changes on d0..d7 afterwards do not affect the result.

Test Plan:
- Reset release, then d0..d7 = 1,2,3,4,5,6,7,8 with in_valid=1 for 1 cycle and out_ready=1 -> out_valid exactly 8 cycles after the accept edge; result=12345678, digit_err=0, ovf=0; in_ready=0 throughout.
- All digits 9 -> result=99999999. All digits 0 -> result=0, out_valid still pulses once.
- out_ready held 0 for 5 cycles in DONE with in_valid=1 and new digits driven -> result stays 12345678 and in_ready stays 0. After out_ready=1, return to IDLE and accept the new word.
- Digits 0,0,0,0,0,0,1,12 -> digit_err=1, result=22. Next valid word 0,...,0,7 -> digit_err=0, result=7.
- Digits 9,9,9,9,9,9,9,100 -> digit_err=1, result=99999999-9+100=100000090, ovf=0.
- Digits 3,0,0,0,0,0,0,0,0-style word with d0 = -1 -> digit_err=1, result negative.
- rst_n pulsed low at the 4th ACCUM cycle -> outputs return to reset values immediately and no out_valid. A fresh word afterwards completes correctly.
- Back-to-back words with out_ready=1 -> consecutive out_valid pulses spaced NDIG+2 cycles apart, with correct results.
